state_seq: RTL and testbench

STATE_SEQ -- requirements
Module: state_seq

---
 rtl/state_seq.sv | 125 ++++++++++++
 tb/tb_state_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/state_seq.sv
// Multicycle instruction control sequencer: IF/ID/EXE/MEM/WB walk per opcode,
// with stop/resume halt, illegal-opcode pulse and retired/active cycle counters.
//
// state | meaning
// IF    | fetch; always advances to ID
// ID    | decode live opcode, latch op_q; parks here while halted on stop
// aEXE  | ALU execute (R_type/ori/addi/slt)
// bEXE  | branch compare (beq/bne), retires from here
// cEXE  | address calculation (lw/sw)
// MEM   | memory access; sw retires, lw continues to cWB
// aWB   | ALU result writeback
// cWB   | load writeback
module state_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [5:0]  opcode,
  input  logic        resume,
  output logic [2:0]  state,
  output logic [5:0]  op_q,
  output logic        halted,
  output logic        illegal,
  output logic        instr_done,
  output logic [15:0] instr_cnt,
  output logic [15:0] cyc_cnt
);

  typedef enum logic [2:0] {
    ST_IF   = 3'b000,
    ST_ID   = 3'b001,
    ST_AEXE = 3'b110,
    ST_BEXE = 3'b101,
    ST_CEXE = 3'b010,
    ST_MEM  = 3'b011,
    ST_AWB  = 3'b111,
    ST_CWB  = 3'b100
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_JUMP  = 6'b111000;
  localparam logic [5:0] OP_STOP  = 6'b111111;

  state_t      state_q, state_nxt;
  logic        halted_q, ill_q, done_q;
  logic        load_op, set_halt, clr_halt, ill_nxt, retire;

  always_comb begin
    state_nxt = state_q;
    load_op   = 1'b0;
    set_halt  = 1'b0;
    clr_halt  = 1'b0;
    ill_nxt   = 1'b0;
    case (state_q)
      ST_IF:   state_nxt = ST_ID;
      ST_ID: begin
        if (halted_q) begin
          if (resume) begin
            state_nxt = ST_IF;
            clr_halt  = 1'b1;
          end
        end else begin
          load_op = 1'b1;
          case (opcode)
            OP_RTYPE, OP_ORI, OP_ADDI, OP_SLT: state_nxt = ST_AEXE;
            OP_BEQ, OP_BNE:                    state_nxt = ST_BEXE;
            OP_LW, OP_SW:                      state_nxt = ST_CEXE;
            OP_JUMP:                           state_nxt = ST_IF;
            OP_STOP:                           set_halt  = 1'b1;
            default: begin
              state_nxt = ST_IF;
              ill_nxt   = 1'b1;
            end
          endcase
        end
      end
      ST_AEXE: state_nxt = ST_AWB;
      ST_AWB:  state_nxt = ST_IF;
      ST_BEXE: state_nxt = ST_IF;
      ST_CEXE: state_nxt = ST_MEM;
      // past ID only the latched opcode steers the walk
      ST_MEM:  state_nxt = (op_q == OP_LW) ? ST_CWB : ST_IF;
      ST_CWB:  state_nxt = ST_IF;
    endcase
  end

  // IF always leaves for ID, so any entry into IF retires an instruction
  assign retire = (state_nxt == ST_IF);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IF;
      op_q      <= 6'b000000;
      halted_q  <= 1'b0;
      ill_q     <= 1'b0;
      done_q    <= 1'b0;
      instr_cnt <= 16'h0000;
      cyc_cnt   <= 16'h0000;
    end else if (en) begin
      state_q  <= state_nxt;
      if (load_op) op_q <= opcode;
      halted_q <= (halted_q | set_halt) & ~clr_halt;
      ill_q    <= ill_nxt;
      done_q   <= retire;
      if (retire)    instr_cnt <= instr_cnt + 16'd1;
      if (!halted_q) cyc_cnt   <= cyc_cnt + 16'd1;
    end else begin
      ill_q  <= 1'b0;
      done_q <= 1'b0;
    end
  end

  // pulses are masked during a stall so they never read as stretched
  assign state      = state_q;
  assign halted     = halted_q;
  assign illegal    = ill_q & en;
  assign instr_done = done_q & en;

endmodule

// File: tb/tb_state_seq.sv
// Bench for state_seq: directed instruction scenarios, with a path-table model
// checked against every output on each falling edge.
module tb_state_seq;

  localparam logic [2:0] S_IF = 3'b000, S_ID = 3'b001, S_AEXE = 3'b110, S_BEXE = 3'b101;
  localparam logic [2:0] S_CEXE = 3'b010, S_MEM = 3'b011, S_AWB = 3'b111, S_CWB = 3'b100;

  localparam logic [5:0] OP_RTYPE = 6'b100000, OP_ORI = 6'b010010, OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_SLT = 6'b100110, OP_SW = 6'b110000, OP_LW = 6'b110001;
  localparam logic [5:0] OP_BEQ = 6'b110100, OP_BNE = 6'b110101, OP_JUMP = 6'b111000;
  localparam logic [5:0] OP_STOP = 6'b111111, OP_BAD = 6'b000111;

  logic        clk = 1'b0;
  logic        rst_n, en, resume;
  logic [5:0]  opcode;
  logic [2:0]  state;
  logic [5:0]  op_q;
  logic        halted, illegal, instr_done;
  logic [15:0] instr_cnt, cyc_cnt;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  state_seq dut (
    .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .resume(resume),
    .state(state), .op_q(op_q), .halted(halted), .illegal(illegal),
    .instr_done(instr_done), .instr_cnt(instr_cnt), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: each opcode is a fixed path of states ----------------
  logic [2:0]  m_path[8];
  int          m_len, m_pos;
  logic        m_halted, m_done, m_ill;
  logic [5:0]  m_op;
  logic [15:0] m_icnt, m_ccnt;

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_ORI, OP_ADDI, OP_SLT, OP_SW, OP_LW,
                      OP_BEQ, OP_BNE, OP_JUMP, OP_STOP};
  endfunction

  task automatic load_path(input logic [5:0] op);
    m_path[0] = S_IF;
    m_path[1] = S_ID;
    if (op inside {OP_RTYPE, OP_ORI, OP_ADDI, OP_SLT}) begin
      m_path[2] = S_AEXE; m_path[3] = S_AWB; m_len = 4;
    end else if (op inside {OP_BEQ, OP_BNE}) begin
      m_path[2] = S_BEXE; m_len = 3;
    end else if (op == OP_SW) begin
      m_path[2] = S_CEXE; m_path[3] = S_MEM; m_len = 4;
    end else if (op == OP_LW) begin
      m_path[2] = S_CEXE; m_path[3] = S_MEM; m_path[4] = S_CWB; m_len = 5;
    end else begin
      m_len = 2;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      load_path(6'b000000);
      m_len = 8; m_pos = 0; m_halted = 1'b0; m_op = 6'b000000;
      m_done = 1'b0; m_ill = 1'b0; m_icnt = 16'h0; m_ccnt = 16'h0;
    end else if (en) begin
      m_done = 1'b0;
      m_ill  = 1'b0;
      if (!m_halted) m_ccnt = m_ccnt + 16'd1;
      if (m_halted) begin
        if (resume) begin
          m_halted = 1'b0; m_pos = 0; m_len = 8; m_done = 1'b1; m_icnt = m_icnt + 16'd1;
        end
      end else if (m_pos == 1 && opcode == OP_STOP) begin
        m_op = opcode;
        m_halted = 1'b1;
      end else begin
        if (m_pos == 1) begin
          m_op = opcode;
          load_path(opcode);
          if (!is_legal(opcode)) m_ill = 1'b1;
        end
        m_pos++;
        if (m_pos >= m_len) begin
          m_pos = 0; m_len = 8; m_done = 1'b1; m_icnt = m_icnt + 16'd1;
        end
      end
    end else begin
      m_done = 1'b0;
      m_ill  = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("state", 32'(state), 32'(m_path[m_pos]));
      chk("op_q", 32'(op_q), 32'(m_op));
      chk("halted", 32'(halted), 32'(m_halted));
      chk("illegal", 32'(illegal), 32'(m_ill & en));
      chk("instr_done", 32'(instr_done), 32'(m_done & en));
      chk("instr_cnt", 32'(instr_cnt), 32'(m_icnt));
      chk("cyc_cnt", 32'(cyc_cnt), 32'(m_ccnt));
    end
  end

  // ---------------- directed stimulus ----------------
  logic [2:0] trace[$];
  logic [2:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // runs one instruction from IF until the next IF, scrambling the live opcode after ID
  task automatic run_instr(input logic [5:0] op);
    int g;
    g = 0;
    opcode = op;
    do begin
      trace.push_back(state);
      tick();
      g++;
      if (g == 2) opcode = ~op;
    end while (state != S_IF && g < 12);
    if (g >= 12) begin
      n_chk++; n_err++;
      $display("FAIL run_instr timeout: got no return to IF, expected one within 12 cycles");
    end
  endtask

  task automatic cmp_trace(input string name);
    chk({name, "_len"}, 32'(trace.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < trace.size(); i++)
      chk(name, 32'(trace[i]), 32'(exp_q[i]));
    trace.delete();
  endtask

  logic [15:0] c0, i0;

  initial begin
    rst_n = 1'b0; en = 1'b1; opcode = 6'b000000; resume = 1'b0;
    tick();
    chk_on = 1'b1;
    tick();
    chk("rst_state", 32'(state), 32'(S_IF));
    chk("rst_icnt", 32'(instr_cnt), 32'd0);
    chk("rst_ccnt", 32'(cyc_cnt), 32'd0);

    // lw from reset
    rst_n = 1'b1;
    run_instr(OP_LW);
    trace.push_back(state);
    exp_q = '{S_IF, S_ID, S_CEXE, S_MEM, S_CWB, S_IF};
    cmp_trace("lw_seq");
    chk("lw_icnt", 32'(instr_cnt), 32'd1);
    chk("lw_ccnt", 32'(cyc_cnt), 32'd5);
    chk("lw_done", 32'(instr_done), 32'd1);
    chk("lw_opq", 32'(op_q), 32'(OP_LW));

    run_instr(OP_SW);
    trace.push_back(state);
    exp_q = '{S_IF, S_ID, S_CEXE, S_MEM, S_IF};
    cmp_trace("sw_seq");

    c0 = instr_cnt;
    run_instr(OP_BEQ);
    run_instr(OP_RTYPE);
    run_instr(OP_JUMP);
    trace.push_back(state);
    exp_q = '{S_IF, S_ID, S_BEXE, S_IF, S_ID, S_AEXE, S_AWB, S_IF, S_ID, S_IF};
    cmp_trace("mix_seq");
    chk("mix_icnt", 32'(instr_cnt - c0), 32'd3);

    // stop / resume
    opcode = OP_STOP;
    tick();
    tick();
    chk("stop_halted", 32'(halted), 32'd1);
    c0 = cyc_cnt;
    i0 = instr_cnt;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("halt_state", 32'(state), 32'(S_ID));
    end
    chk("halt_ccnt", 32'(cyc_cnt), 32'(c0));
    resume = 1'b1;
    tick();
    resume = 1'b0;
    opcode = OP_JUMP;
    chk("resume_state", 32'(state), 32'(S_IF));
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_icnt", 32'(instr_cnt), 32'(i0 + 16'd1));
    chk("resume_done", 32'(instr_done), 32'd1);
    tick();
    tick();

    // illegal opcode
    i0 = instr_cnt;
    opcode = OP_BAD;
    tick();
    tick();
    chk("ill_pulse", 32'(illegal), 32'd1);
    chk("ill_state", 32'(state), 32'(S_IF));
    chk("ill_icnt", 32'(instr_cnt), 32'(i0 + 16'd1));
    opcode = OP_JUMP;
    tick();
    chk("ill_clear", 32'(illegal), 32'd0);
    tick();

    // resume while running is ignored
    resume = 1'b1;
    run_instr(OP_ORI);
    resume = 1'b0;
    trace.push_back(state);
    exp_q = '{S_IF, S_ID, S_AEXE, S_AWB, S_IF};
    cmp_trace("ori_seq");
    run_instr(OP_BNE);
    run_instr(OP_SLT);
    trace.delete();

    // stall in aEXE
    opcode = OP_ADDI;
    tick();
    tick();
    chk("stall_entry", 32'(state), 32'(S_AEXE));
    en = 1'b0;
    c0 = cyc_cnt;
    i0 = instr_cnt;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_state", 32'(state), 32'(S_AEXE));
      chk("stall_ccnt", 32'(cyc_cnt), 32'(c0));
      chk("stall_icnt", 32'(instr_cnt), 32'(i0));
    end
    en = 1'b1;
    tick();
    tick();
    chk("stall_retire", 32'(instr_cnt), 32'(i0 + 16'd1));

    // reset while in MEM, with en low
    opcode = OP_LW;
    tick();
    tick();
    tick();
    chk("mem_entry", 32'(state), 32'(S_MEM));
    rst_n = 1'b0;
    en = 1'b0;
    tick();
    chk("mrst_state", 32'(state), 32'(S_IF));
    chk("mrst_opq", 32'(op_q), 32'd0);
    chk("mrst_icnt", 32'(instr_cnt), 32'd0);
    chk("mrst_ccnt", 32'(cyc_cnt), 32'd0);
    chk("mrst_halted", 32'(halted), 32'd0);
    rst_n = 1'b1;
    en = 1'b1;
    tick();
    chk("post_rst_state", 32'(state), 32'(S_ID));
    tick();
    @(negedge clk);
    chk_on = 1'b0;
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
